// File: rtl/pipe_pkg.sv
// pipe_pkg: shared slot state encoding and occupancy width helper for the skid pipeline
package pipe_pkg;
   typedef enum logic [1:0] {EMPTY, BUSY, FULL} slot_state_t;
   function automatic int occ_w(input int depth);
      return $clog2(2 * depth + 1);
   endfunction
endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one pipeline slot with a main and a skid register and a registered ready
module pipe_skid_slot import pipe_pkg::*; #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 96
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o
);
   localparam int W = CTRL_W + DATA_W;
   slot_state_t  state_q;
   logic         ready_q;
   logic [W-1:0] main_q, skid_q, in_w;
   logic         acc, drn;
   assign in_w        = {in_ctrl_i, in_data_i};
   assign out_valid_o = state_q != EMPTY;
   assign in_ready_o  = ready_q;
   assign acc         = in_valid_i & ready_q;
   assign drn         = out_valid_o & out_ready_i;
   assign {out_ctrl_o, out_data_o} = main_q;
   // ready_q mirrors "skid will be empty after this edge"; held low through reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
         ready_q <= 1'b0;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (flush_i) begin
         state_q <= EMPTY;
         ready_q <= 1'b1;
      end else begin
         ready_q <= (state_q != FULL) || drn;
         case (state_q)
            EMPTY: if (acc) begin
               state_q <= BUSY;
               main_q  <= in_w;
            end
            BUSY: if (acc && !drn) begin
               state_q <= FULL;
               skid_q  <= in_w;
               ready_q <= 1'b0;
            end else if (acc) begin
               main_q <= in_w;
            end else if (drn) begin
               state_q <= EMPTY;
            end
            FULL: if (drn) begin
               state_q <= BUSY;
               main_q  <= skid_q;
            end
            default: state_q <= EMPTY;
         endcase
      end
   end
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: DEPTH chained skid slots with occupancy count and bubble-gated outputs
module pipe_skid_stage import pipe_pkg::*; #(
   parameter  int CTRL_W = 8,
   parameter  int DATA_W = 96,
   parameter  int DEPTH  = 1,
   localparam int OCC_W  = occ_w(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [OCC_W-1:0]  occupancy_o
);
   logic              v [DEPTH+1];
   logic              r [DEPTH+1];
   logic [CTRL_W-1:0] c [DEPTH+1];
   logic [DATA_W-1:0] d [DEPTH+1];
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              acc, drn;
   assign v[0]     = in_valid_i;
   assign c[0]     = in_ctrl_i;
   assign d[0]     = in_data_i;
   assign r[DEPTH] = out_ready_i;
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .flush_i     (flush_i),
         .in_valid_i  (v[i]),
         .in_ready_o  (r[i]),
         .in_ctrl_i   (c[i]),
         .in_data_i   (d[i]),
         .out_valid_o (v[i+1]),
         .out_ready_i (r[i+1]),
         .out_ctrl_o  (c[i+1]),
         .out_data_o  (d[i+1])
      );
   end
   assign acc         = in_valid_i & r[0];
   assign drn         = v[DEPTH] & out_ready_i;
   assign occ_d       = flush_i ? '0 : occ_q + OCC_W'(acc) - OCC_W'(drn);
   assign in_ready_o  = r[0];
   assign out_valid_o = v[DEPTH];
   assign out_ctrl_o  = v[DEPTH] ? c[DEPTH] : '0;
   assign out_data_o  = v[DEPTH] ? d[DEPTH] : '0;
   assign occupancy_o = occ_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) occ_q <= '0;
      else         occ_q <= occ_d;
   end
endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with valid/ready handshaking, replacing fixed-field inter-stage latches such as EX/MEM. It carries an opaque control bundle and a data bundle through DEPTH chained slots. Each slot has a two-entry skid buffer, so a back-pressure stall never drops or duplicates an instruction and every ready path is registered. Synchronous flush and gating of control to zero on bubbles let downstream stages treat an invalid slot as a NOP.

## Interface
- CTRL_W, 8: control bits (RegWrite, MemWrite, …); forced to 0 on any bubble
- DATA_W, 96: payload bits (ALU result, store data, PC+4, …)
- DEPTH, 1: number of chained slots, 1..4
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Flush  in  1  synchronous kill of all slots
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept; registered
- in_ctrl  in  CTRL_W  control of incoming entry
- in_data  in  DATA_W  payload of incoming entry
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_ctrl  out  CTRL_W  head control; 0 when out_valid=0
- out_data  out  DATA_W  head payload; 0 when out_valid=0
- occupancy  out  $clog2(2*DEPTH+1)  entries held across all slots

## Operation
- Transfer occurs on an edge when valid=1 and ready=1 at that interface.
- Each slot has a main register and a skid register. Slot state is one of EMPTY, BUSY (main valid) or FULL (main and skid valid).
- Slot ready = !skid_valid. It is taken from a flop, never from out_ready.
- EMPTY: accept → BUSY, main <= input.
- BUSY:
  - accept and drain → BUSY, main <= input.
  - accept without drain → FULL, skid <= input.
  - drain without accept → EMPTY.
- FULL: drain → BUSY, main <= skid. No accept is possible.
- Slots chain head-to-tail. Slot k's output feeds slot k+1's input, and the last slot drives out_*.
- Ordering is strict FIFO. No entry is ever dropped or duplicated except by Flush.
- Flush has priority over every transfer.
  - Next edge: all slots EMPTY and occupancy 0.
  - An entry presented on in_* in the flush cycle is discarded, even if in_ready=1.
  - An out_* transfer in the flush cycle still counts as completed downstream.
- out_ctrl and out_data are AND-gated with out_valid.
- occupancy updates with the edge: +1 on accept, −1 on drain, unchanged on both or neither. It never exceeds 2*DEPTH.
- No arithmetic on payload. PC and other fields pass through unmodified.

## Timing
- Reset low (asynchronous): all slots EMPTY, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0 while held low.
- First edge after Reset rises: in_ready=1.
- Latency is DEPTH cycles from accept to out_valid with the pipeline empty and out_ready=1.
- Throughput is 1 entry/cycle sustained with out_ready=1.
- When out_ready drops, the last slot absorbs one extra entry. in_ready of slot 0 falls after at most DEPTH edges, and no entry is lost.
- After out_ready rises again, the first drain occurs the same edge. in_ready recovers one edge after the relevant skid empties.
- Reset asserted mid-operation: immediate clear as above, and all in-flight entries are lost.
- Flush and Reset together: Reset wins.

## Structure
- pipe_pkg:
  - slot_state_t enum (EMPTY, BUSY, FULL).
  - Helper localparam OCC_W = $clog2(2*DEPTH+1).
- Sub-module pipe_skid_slot: one slot (main plus skid plus state), CTRL_W/DATA_W parametrised.
- pipe_skid_stage:
  - generate-loop of DEPTH pipe_skid_slot instances.
  - occupancy counter.
  - output gating.

## Test plan
- Reset then stream: DEPTH=2, in_valid=1 with ctrl 0x01..0x05, out_ready=1. → out_valid rises 2 cycles after first accept; outputs 0x01..0x05 in order, one per cycle; occupancy steady at 2.
- Back-pressure: DEPTH=1, stream 0xA0..0xA3, out_ready=0 for 3 cycles starting after first accept. → in_ready falls after second accept; occupancy=2; on release, output 0xA0,0xA1,0xA2,0xA3, with no gap after the first drain.
- Flush with full pipe: DEPTH=2, occupancy=4, Flush=1 while in_valid=1 with ctrl 0xFF. → next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xFF never appears.
- Bubble gating: in_valid=0 with in_ctrl=0xFF and in_data all-ones. → out_ctrl=0 and out_data=0 for all cycles.
- Async reset mid-stream: pull Reset low between edges with occupancy=3. → outputs and occupancy zero immediately, before the next edge; in_ready=0 until the first edge after release.
- Random valid/ready: 10k cycles against a scoreboard. → exact in-order match and occupancy ≤ 2*DEPTH for DEPTH=1..4.
